// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared RAM port arbiter for instruction fetch and data load/store
//
// Purpose: sequences one RAM port between a fetch requester and a data requester.
//   Data requests win over fetch. Sub-word loads are lane-extracted and extended,
//   sub-word stores run a read-modify-write. Every access ends in a one-cycle RESP
//   state that carries the requester's hit pulse (plus timeout_err if aborted).
//
// Ports:
//   CLK, nRST                 clock, asynchronous active-low reset
//   iren, imemaddr            fetch request (level) and byte address
//   ihit, imemload            fetch done pulse and fetched word
//   dren, dwen                data load / store requests (level)
//   dsize, dunsigned          access size (00 byte, 01 half, 1x word), load extension
//   dmmaddr, dmmstore         data byte address, right-aligned store data
//   dhit, dmmload             data done pulse and extended load data
//   ramaddr, ramstore         word address and write data to RAM
//   ramload                   read data from RAM, valid on a non-busy strobe cycle
//   Ren, Wen, busy_o          RAM strobes and RAM busy
//   timeout_err               pulses with the hit of an aborted access
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iren,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        dren,
  input  logic        dwen,
  input  logic [1:0]  dsize,
  input  logic        dunsigned,
  input  logic [31:0] dmmaddr,
  input  logic [31:0] dmmstore,
  output logic        dhit,
  output logic [31:0] dmmload,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  output logic        Ren,
  output logic        Wen,
  input  logic        busy_o,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IREAD  = 3'd1,
    S_DREAD  = 3'd2,
    S_DWRITE = 3'd3,
    S_RMW_RD = 3'd4,
    S_RMW_WR = 3'd5,
    S_RESP   = 3'd6
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       lane_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [15:0]      sdata_q;

  // Word-aligned addresses only ever reach the RAM; the low fetch bits carry no meaning.
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^imemaddr[1:0];

  // The counter holds the number of busy strobe cycles already seen, so the
  // TIMEOUT-th busy cycle is the one that finds it at TIMEOUT-1.
  logic last_busy;
  assign last_busy = (cnt_q == CNT_W'(TIMEOUT - 1));

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  // Only used for byte/half stores; halfwords ignore addr[0].
  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic [15:0] sdata);
    logic [31:0] m;
    m = word;
    if (size == 2'b00) m[{lane, 3'b000} +: 8] = sdata[7:0];
    else               m[{lane[1], 4'b0000} +: 16] = sdata;
    return m;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      sdata_q     <= '0;
      ihit        <= 1'b0;
      dhit        <= 1'b0;
      timeout_err <= 1'b0;
      imemload    <= '0;
      dmmload     <= '0;
      ramaddr     <= '0;
      ramstore    <= '0;
      Ren         <= 1'b0;
      Wen         <= 1'b0;
    end else begin
      ihit        <= 1'b0;
      dhit        <= 1'b0;
      timeout_err <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q   <= '0;
          // Request attributes are captured here so a requester that drops or
          // changes its inputs mid-access cannot disturb the access in flight.
          lane_q  <= dmmaddr[1:0];
          size_q  <= dsize;
          uns_q   <= dunsigned;
          sdata_q <= dmmstore[15:0];
          if (dwen) begin
            ramaddr <= {dmmaddr[31:2], 2'b00};
            if (dsize[1]) begin
              state_q  <= S_DWRITE;
              Wen      <= 1'b1;
              ramstore <= dmmstore;
            end else begin
              state_q <= S_RMW_RD;
              Ren     <= 1'b1;
            end
          end else if (dren) begin
            ramaddr <= {dmmaddr[31:2], 2'b00};
            state_q <= S_DREAD;
            Ren     <= 1'b1;
          end else if (iren) begin
            ramaddr <= {imemaddr[31:2], 2'b00};
            state_q <= S_IREAD;
            Ren     <= 1'b1;
          end
        end

        S_RESP: begin
          state_q <= S_IDLE;
        end

        S_IREAD, S_DREAD, S_DWRITE, S_RMW_RD, S_RMW_WR: begin
          if (!busy_o) begin
            cnt_q <= '0;
            case (state_q)
              S_IREAD: begin
                imemload <= ramload;
                ihit     <= 1'b1;
                Ren      <= 1'b0;
                state_q  <= S_RESP;
              end
              S_DREAD: begin
                dmmload <= extend_load(ramload, lane_q, size_q, uns_q);
                dhit    <= 1'b1;
                Ren     <= 1'b0;
                state_q <= S_RESP;
              end
              S_RMW_RD: begin
                ramstore <= merge_store(ramload, lane_q, size_q, sdata_q);
                Ren      <= 1'b0;
                Wen      <= 1'b1;
                state_q  <= S_RMW_WR;
              end
              default: begin
                dhit    <= 1'b1;
                Wen     <= 1'b0;
                state_q <= S_RESP;
              end
            endcase
          end else if (last_busy) begin
            // Abort: the owning requester still gets its hit, with zero data.
            // An aborted read phase of a read-modify-write never issues its write.
            cnt_q       <= cnt_q + 1'b1;
            Ren         <= 1'b0;
            Wen         <= 1'b0;
            timeout_err <= 1'b1;
            state_q     <= S_RESP;
            if (state_q == S_IREAD) begin
              ihit     <= 1'b1;
              imemload <= '0;
            end else begin
              dhit    <= 1'b1;
              dmmload <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          Ren     <= 1'b0;
          Wen     <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        CLK, nRST;
  logic        iren, dren, dwen, dunsigned, busy_o;
  logic [31:0] imemaddr, dmmaddr, dmmstore;
  logic [1:0]  dsize;
  logic        ihit, dhit, Ren, Wen, timeout_err;
  logic [31:0] imemload, dmmload, ramaddr, ramstore, ramload;

  logic        use_mem, init_req;
  logic [31:0] ramload_drv;
  logic [31:0] mem      [64];
  logic [31:0] seed_mem [64];
  logic [31:0] ref_mem  [64];
  logic        busy_seq [64];

  int n_cmp, n_fail;

  mem_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
    .CLK(CLK), .nRST(nRST),
    .iren(iren), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .dren(dren), .dwen(dwen), .dsize(dsize), .dunsigned(dunsigned),
    .dmmaddr(dmmaddr), .dmmstore(dmmstore), .dhit(dhit), .dmmload(dmmload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
    .Ren(Ren), .Wen(Wen), .busy_o(busy_o), .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Simple RAM: combinational read, write on a non-busy Wen cycle.
  assign ramload = use_mem ? mem[ramaddr[7:2]] : ramload_drv;
  always @(posedge CLK) begin
    if (init_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed_mem[i];
    end else if (Wen && !busy_o) begin
      mem[ramaddr[7:2]] <= ramstore;
    end
  end

  typedef struct {
    int          kind;      // 0 fetch, 1 load, 2 store
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] st;
    logic [31:0] ram;
    int          nb;        // busy cycles starting at cycle 1
    int          exp_hit;   // cycle of the hit, request raised in cycle 0
    logic [31:0] exp_data;
    logic        exp_terr;
    logic        exp_wen;
    logic [31:0] exp_rs;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic u);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (w >> (8 * a[1:0])) & 32'hFF;
      if (!u && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'b01) begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      if (!u && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] s);
    logic [31:0] sh, mask;
    if (sz[1]) return s;
    sh   = (sz == 2'b00) ? 8 * a[1:0] : 16 * a[1];
    mask = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((s << sh) & mask);
  endfunction

  // Raises one request in the current (IDLE) cycle, drives busy_o from busy_seq,
  // waits for the hit and leaves the bench in the following IDLE cycle.
  task automatic run_txn(input string nm, input int kind, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] st,
                         input int exp_hit, input logic [31:0] exp_data, input logic exp_terr,
                         input logic exp_wen, input logic [31:0] exp_rs);
    int          hc;
    logic        got_i, got_d, got_t, wen_seen, both, ren1, wen1;
    logic [31:0] got_data, addr1, rs_seen;
    hc = -1; got_i = 0; got_d = 0; got_t = 0; wen_seen = 0; both = 0; ren1 = 0; wen1 = 0;
    got_data = 0; addr1 = 0; rs_seen = 0;
    iren = (kind == 0); dren = (kind == 1); dwen = (kind == 2);
    imemaddr = addr; dmmaddr = addr; dsize = size; dunsigned = uns; dmmstore = st;
    for (int c = 0; c < 64 && hc < 0; c++) begin
      busy_o = busy_seq[c];
      if (c == 1) begin addr1 = ramaddr; ren1 = Ren; wen1 = Wen; end
      if (Ren && Wen) both = 1;
      if (Wen) begin wen_seen = 1; rs_seen = ramstore; end
      if (ihit || dhit) begin
        hc = c; got_i = ihit; got_d = dhit; got_t = timeout_err;
        got_data = (kind == 0) ? imemload : dmmload;
      end
      step();
    end
    iren = 0; dren = 0; dwen = 0;
    chk({nm, "_hit_cycle"}, hc, exp_hit);
    chk({nm, "_hit_owner"}, 32'({got_i, got_d}), (kind == 0) ? 32'h2 : 32'h1);
    chk({nm, "_timeout_err"}, 32'(got_t), 32'(exp_terr));
    chk({nm, "_ramaddr"}, addr1, {addr[31:2], 2'b00});
    chk({nm, "_first_strobe"}, 32'({ren1, wen1}), (kind == 2 && size[1]) ? 32'h1 : 32'h2);
    chk({nm, "_ren_wen_excl"}, 32'(both), 32'h0);
    if (kind != 2) chk({nm, "_data"}, got_data, exp_data);
    else begin
      chk({nm, "_wen_seen"}, 32'(wen_seen), 32'(exp_wen));
      if (exp_wen) chk({nm, "_ramstore"}, rs_seen, exp_rs);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, ic, hc, need, cnt, eh, run, kind, idx;
    logic [31:0] a, s, ed, ers;
    logic [1:0]  sz;
    logic        u, b;

    n_cmp = 0; n_fail = 0;
    nRST = 0; iren = 0; dren = 0; dwen = 0; dunsigned = 0; busy_o = 0;
    imemaddr = 0; dmmaddr = 0; dmmstore = 0; dsize = 0;
    use_mem = 0; init_req = 0; ramload_drv = 0;
    for (int c = 0; c < 64; c++) busy_seq[c] = 0;

    vt[0]  = '{0, 32'hABCDABCD, 2'b10, 1'b0, 32'h0,        32'h12341234, 0,  2,  32'h12341234, 1'b0, 1'b0, 32'h0};
    vt[1]  = '{1, 32'h56785678, 2'b10, 1'b0, 32'h0,        32'h0BADF00D, 0,  2,  32'h0BADF00D, 1'b0, 1'b0, 32'h0};
    vt[2]  = '{1, 32'h00000013, 2'b00, 1'b0, 32'h0,        32'h80FF7F01, 0,  2,  32'hFFFFFF80, 1'b0, 1'b0, 32'h0};
    vt[3]  = '{1, 32'h00000013, 2'b00, 1'b1, 32'h0,        32'h80FF7F01, 0,  2,  32'h00000080, 1'b0, 1'b0, 32'h0};
    vt[4]  = '{1, 32'h00000002, 2'b01, 1'b0, 32'h0,        32'h80FF7F01, 0,  2,  32'hFFFF80FF, 1'b0, 1'b0, 32'h0};
    vt[5]  = '{1, 32'h00000001, 2'b01, 1'b0, 32'h0,        32'h00008001, 0,  2,  32'hFFFF8001, 1'b0, 1'b0, 32'h0};
    vt[6]  = '{1, 32'h00000006, 2'b01, 1'b1, 32'h0,        32'h80FF7F01, 0,  2,  32'h000080FF, 1'b0, 1'b0, 32'h0};
    vt[7]  = '{1, 32'h00000000, 2'b11, 1'b0, 32'h0,        32'h80FF7F01, 0,  2,  32'h80FF7F01, 1'b0, 1'b0, 32'h0};
    vt[8]  = '{2, 32'h00000011, 2'b00, 1'b0, 32'h33333333, 32'hAABBCCDD, 0,  3,  32'h0,        1'b0, 1'b1, 32'hAABB33DD};
    vt[9]  = '{2, 32'h00000003, 2'b01, 1'b0, 32'h12345678, 32'hAABBCCDD, 0,  3,  32'h0,        1'b0, 1'b1, 32'h5678CCDD};
    vt[10] = '{2, 32'h00000020, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        0,  2,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vt[11] = '{2, 32'h00000002, 2'b00, 1'b0, 32'h000000EE, 32'h11223344, 2,  5,  32'h0,        1'b0, 1'b1, 32'h11EE3344};
    vt[12] = '{1, 32'h00000044, 2'b10, 1'b0, 32'h0,        32'hCAFEF00D, 3,  5,  32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
    vt[13] = '{1, 32'h00000048, 2'b10, 1'b0, 32'h0,        32'hCAFEF00D, 99, 17, 32'h0,        1'b1, 1'b0, 32'h0};
    vt[14] = '{0, 32'h0000004C, 2'b10, 1'b0, 32'h0,        32'hCAFEF00D, 99, 17, 32'h0,        1'b1, 1'b0, 32'h0};
    vt[15] = '{2, 32'h00000050, 2'b00, 1'b0, 32'h000000AB, 32'hCAFEF00D, 99, 17, 32'h0,        1'b1, 1'b0, 32'h0};

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_strobes", 32'({Ren, Wen}), 32'h0);
    chk("reset_hits", 32'({ihit, dhit, timeout_err}), 32'h0);
    chk("reset_ramaddr", ramaddr, 32'h0);
    chk("reset_ramstore", ramstore, 32'h0);
    chk("reset_loads", imemload | dmmload, 32'h0);
    nRST = 1;
    step(); step();
    chk("idle_after_reset", 32'({Ren, Wen, ihit, dhit, timeout_err}), 32'h0);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      for (int c = 0; c < 64; c++) busy_seq[c] = (c >= 1 && c <= vt[i].nb);
      ramload_drv = vt[i].ram;
      run_txn($sformatf("vec%0d", i), vt[i].kind, vt[i].addr, vt[i].size, vt[i].uns, vt[i].st,
              vt[i].exp_hit, vt[i].exp_data, vt[i].exp_terr, vt[i].exp_wen, vt[i].exp_rs);
    end

    // Data beats fetch when both arrive together; the fetch follows after RESP/IDLE
    busy_o = 0; ramload_drv = 32'h0F0F0F0F;
    iren = 1; dren = 1; imemaddr = 32'h00000100; dmmaddr = 32'h56785678; dsize = 2'b10;
    dc = -1; ic = -1;
    for (int c = 0; c < 20 && ic < 0; c++) begin
      if (c == 1) begin
        chk("prio_ramaddr", ramaddr, 32'h56785678);
        chk("prio_ren", 32'(Ren), 32'h1);
      end
      if (dhit && dc < 0) begin dc = c; dren = 0; end
      if (ihit) begin ic = c; iren = 0; end
      step();
    end
    iren = 0; dren = 0;
    chk("prio_dhit_cycle", dc, 2);
    chk("prio_ihit_gap", ic - dc, 3);

    // Store wins over load
    dren = 1; dwen = 1; dsize = 2'b10; dmmaddr = 32'h40; dmmstore = 32'h5A5A5A5A;
    step();
    chk("store_wins_strobe", 32'({Ren, Wen}), 32'h1);
    hc = -1;
    for (int c = 1; c < 12 && hc < 0; c++) begin
      if (dhit) hc = c; else step();
    end
    chk("store_wins_dhit_cycle", hc, 2);
    dren = 0; dwen = 0;
    step();

    // Request dropped mid-access still completes
    iren = 1; imemaddr = 32'h60; ramload_drv = 32'h600DF00D; busy_o = 0;
    step();
    iren = 0; busy_o = 1;
    step(); step();
    busy_o = 0; hc = -1;
    for (int c = 3; c < 12 && hc < 0; c++) begin
      if (ihit) hc = c; else step();
    end
    chk("drop_ihit_cycle", hc, 4);
    chk("drop_imemload", imemload, 32'h600DF00D);
    step();

    // Asynchronous reset in the middle of a write
    dwen = 1; dsize = 2'b10; dmmaddr = 32'h80; dmmstore = 32'h12345678; busy_o = 1;
    step(); step();
    chk("rst_pre_wen", 32'(Wen), 32'h1);
    #2 nRST = 0;
    #1;
    chk("rst_async_drop", 32'({Ren, Wen, ihit, dhit}), 32'h0);
    dwen = 0; busy_o = 0;
    @(posedge CLK);
    #1 nRST = 1;
    repeat (3) step();
    chk("rst_idle_ctrl", 32'({Ren, Wen, ihit, dhit, timeout_err}), 32'h0);
    chk("rst_idle_ramaddr", ramaddr, 32'h0);
    chk("rst_idle_ramstore", ramstore, 32'h0);

    // Randomized traffic against a word-array reference memory
    for (int i = 0; i < 64; i++) begin
      seed_mem[i] = $urandom;
      ref_mem[i]  = seed_mem[i];
    end
    init_req = 1;
    step();
    init_req = 0; use_mem = 1;
    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 2);
      a = $urandom; sz = 2'($urandom_range(0, 3)); u = 1'($urandom_range(0, 1)); s = $urandom;
      idx = int'(a[7:2]);
      run = 0;
      for (int c = 0; c < 64; c++) begin
        b = ($urandom_range(0, 3) == 0) && (run < 3);
        busy_seq[c] = b;
        run = b ? run + 1 : 0;
      end
      need = (kind == 2 && !sz[1]) ? 2 : 1;
      cnt = 0; eh = -1;
      for (int k = 1; k < 64 && eh < 0; k++) begin
        if (!busy_seq[k]) begin
          cnt++;
          if (cnt == need) eh = k + 1;
        end
      end
      ed = 0; ers = 0;
      if (kind == 0) ed = ref_mem[idx];
      else if (kind == 1) ed = model_load(ref_mem[idx], a, sz, u);
      else begin
        ers = model_store(ref_mem[idx], a, sz, s);
        ref_mem[idx] = ers;
      end
      run_txn($sformatf("rnd%0d", t), kind, a, sz, u, s, eh, ed, 1'b0, 1'b1, ers);
    end
    step();
    for (int i = 0; i < 64; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
